mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a word-wide, big-endian data memory; SB/SH via read-modify-write.
// Latency from accept edge: error -> resp same edge, load/SW -> 1 strobe cycle then resp, SB/SH -> read, write, then resp.
// Backpressure: req_ready is high only in IDLE; one request in flight, request inputs ignored while busy.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    state_t            state, state_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       wd_q, wd_d;
    logic              req_ready_d, resp_valid_d, resp_err_d, mem_read_d, mem_write_d;
    logic [31:0]       resp_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: return off[0];
            OP_LW, OP_SW:         return (off != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Byte at offset 0 lives on [31:24] (big-endian lanes).
    function automatic logic [31:0] load_extract(input logic [3:0] op, input logic [1:0] off,
                                                 input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[31:24];
            2'd1:    b = rd[23:16];
            2'd2:    b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = off[1] ? rd[15:0] : rd[31:16];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return rd;
        endcase
    endfunction

    // Overlay the store byte/half onto the word just read; other lanes are preserved.
    function automatic logic [31:0] store_merge(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] rd, input logic [15:0] wd);
        logic [31:0] m;
        m = rd;
        if (op == OP_SH) begin
            if (off[1]) m[15:0]  = wd;
            else        m[31:16] = wd;
        end else begin
            case (off)
                2'd0:    m[31:24] = wd[7:0];
                2'd1:    m[23:16] = wd[7:0];
                2'd2:    m[15:8]  = wd[7:0];
                default: m[7:0]   = wd[7:0];
            endcase
        end
        return m;
    endfunction

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= '0;
            off_q      <= '0;
            wd_q       <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            state      <= state_d;
            op_q       <= op_d;
            off_q      <= off_d;
            wd_q       <= wd_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
        end
    end

    // Next state and the next value of every registered output.
    always_comb begin
        state_d      = state;
        op_d         = op_q;
        off_d        = off_q;
        wd_d         = wd_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    off_d = req_addr[1:0];
                    wd_d  = req_wdata[15:0];
                    if (!op_legal(req_op) || misaligned(req_op, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (is_load(req_op)) begin
                            state_d    = RD;
                            mem_read_d = 1'b1;
                        end else if (req_op == OP_SW) begin
                            state_d     = WR;
                            mem_write_d = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d    = RMW_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_extract(op_q, off_q, mem_rdata);
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RMW_RD: begin
                state_d     = RMW_WR;
                mem_write_d = 1'b1;
                mem_wdata_d = store_merge(op_q, off_q, mem_rdata, wd_q);
            end
            RMW_WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Bench memory: 64 words, whole-word writes at posedge, read data combinational.
    logic [31:0] mem [0:63];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (mem_write === 1'b1) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    // Reference model: flat byte array, big-endian, one transaction at a time.
    logic [7:0] rb [0:255];

    function automatic logic [31:0] rb_word(input int a);
        int b;
        b = a & ~3;
        return {rb[b], rb[b+1], rb[b+2], rb[b+3]};
    endfunction

    task automatic ref_op(input logic [3:0] op, input logic [7:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int nr, output int nw, output logic [31:0] ww);
        int sz;
        logic ld, st;
        logic [31:0] val;
        sz = 1; ld = 1'b0; st = 1'b0;
        case (op)
            4'd0, 4'd4: begin sz = 1; ld = 1'b1; end
            4'd1, 4'd5: begin sz = 2; ld = 1'b1; end
            4'd3:       begin sz = 4; ld = 1'b1; end
            4'd8:       begin sz = 1; st = 1'b1; end
            4'd9:       begin sz = 2; st = 1'b1; end
            4'd11:      begin sz = 4; st = 1'b1; end
            default: ;
        endcase
        err = !(ld || st) || ((int'(a) % sz) != 0);
        rd = 0; ww = 0; lat = 1; nr = 0; nw = 0;
        if (!err && ld) begin
            val = 0;
            for (int i = 0; i < sz; i++) val = (val << 8) | 32'(rb[int'(a) + i]);
            if (op == 4'd0 && val[7])  val = val | 32'hFFFFFF00;
            if (op == 4'd1 && val[15]) val = val | 32'hFFFF0000;
            rd = val; nr = 1; lat = 2;
        end
        if (!err && st) begin
            for (int i = 0; i < sz; i++) rb[int'(a) + i] = 8'(wd >> (8 * (sz - 1 - i)));
            nw = 1;
            nr = (sz == 4) ? 0 : 1;
            lat = (sz == 4) ? 2 : 3;
            ww = rb_word(int'(a));
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and observe it until resp_valid (bounded), counting strobes.
    task automatic do_req(input logic [3:0] op, input logic [7:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err, output int lat,
                          output int nr, output int nw, output int nbad, output logic [31:0] ww);
        int guard;
        rd = 0; err = 0; lat = 0; nr = 0; nw = 0; nbad = 0; ww = 0;
        guard = 0;
        while (!req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        req_valid = 1'b1; req_op = op; req_addr = {24'd0, a}; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; guard = 0;
        while (!resp_valid && guard < 20) begin
            if (mem_read) nr++;
            if (mem_write) begin nw++; ww = mem_wdata; end
            if (mem_read && mem_write) nbad++;
            if ((mem_read || mem_write) && mem_addr !== {24'd0, a[7:2], 2'b00}) nbad++;
            if (req_ready) nbad++;
            @(posedge clk); #1;
            lat++; guard++;
        end
        if (!resp_valid) lat = 99;
        rd = resp_rdata; err = resp_err;
        if (mem_read || mem_write || req_ready) nbad++;
        @(posedge clk); #1;
        if (resp_valid) nbad++;
    endtask

    task automatic run_check(input string name, input logic [3:0] op, input logic [7:0] a,
                             input logic [31:0] wd, input logic [31:0] e_rd, input logic e_err,
                             input int e_lat, input int e_nr, input int e_nw, input logic [31:0] e_ww);
        logic [31:0] rd, ww;
        logic err;
        int lat, nr, nw, nbad;
        do_req(op, a, wd, rd, err, lat, nr, nw, nbad, ww);
        chk({name, " rdata"}, rd, e_rd);
        chk({name, " err"}, 32'(err), 32'(e_err));
        chk({name, " latency"}, lat, e_lat);
        chk({name, " reads"}, nr, e_nr);
        chk({name, " writes"}, nw, e_nw);
        chk({name, " protocol"}, nbad, 0);
        if (e_nw > 0) chk({name, " wdata"}, ww, e_ww);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nr;
        int          nw;
        logic [31:0] ww;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [31:0] m_rd, m_ww, pre_word;
        logic m_err;
        int m_lat, m_nr, m_nw, cnt_w, cnt_r, idx, resp_cnt, busy_rdy;
        logic acc;
        logic [3:0] b_op [4];
        logic [7:0] b_ad [4];
        logic [3:0] legal_ops [8];
        logic [3:0] op;
        logic [7:0] a;
        logic [31:0] wd;

        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 4; k++) rb[4*i + k] = 8'(init_word(i) >> (24 - 8*k));
        end

        vecs[0]  = '{"SW 8",    4'b1011, 8'h08, 32'h80F12233, 32'h00000000, 1'b0, 2, 0, 1, 32'h80F12233};
        vecs[1]  = '{"LB 8",    4'b0000, 8'h08, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h0};
        vecs[2]  = '{"LBU 9",   4'b0100, 8'h09, 32'h0,        32'h000000F1, 1'b0, 2, 1, 0, 32'h0};
        vecs[3]  = '{"LH A",    4'b0001, 8'h0A, 32'h0,        32'h00002233, 1'b0, 2, 1, 0, 32'h0};
        vecs[4]  = '{"LH 8",    4'b0001, 8'h08, 32'h0,        32'hFFFF80F1, 1'b0, 2, 1, 0, 32'h0};
        vecs[5]  = '{"LHU 8",   4'b0101, 8'h08, 32'h0,        32'h000080F1, 1'b0, 2, 1, 0, 32'h0};
        vecs[6]  = '{"LW 8",    4'b0011, 8'h08, 32'h0,        32'h80F12233, 1'b0, 2, 1, 0, 32'h0};
        vecs[7]  = '{"SB B",    4'b1000, 8'h0B, 32'h000000AA, 32'h00000000, 1'b0, 3, 1, 1, 32'h80F122AA};
        vecs[8]  = '{"SH 8",    4'b1001, 8'h08, 32'h00001234, 32'h00000000, 1'b0, 3, 1, 1, 32'h123422AA};
        vecs[9]  = '{"LW 8 b",  4'b0011, 8'h08, 32'h0,        32'h123422AA, 1'b0, 2, 1, 0, 32'h0};
        vecs[10] = '{"LW 6",    4'b0011, 8'h06, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h0};
        vecs[11] = '{"SH 3",    4'b1001, 8'h03, 32'h0000BEEF, 32'h00000000, 1'b1, 1, 0, 0, 32'h0};
        vecs[12] = '{"op 0010", 4'b0010, 8'h00, 32'h0,        32'h00000000, 1'b1, 1, 0, 0, 32'h0};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset flags", {28'd0, resp_valid, resp_err, mem_read, mem_write}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            ref_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_lat, m_nr, m_nw, m_ww);
            run_check(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                      vecs[i].err, vecs[i].lat, vecs[i].nr, vecs[i].nw, vecs[i].ww);
        end

        // Reset while SB sits in its read cycle: write must never happen.
        pre_word = rb_word(4);
        req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h4; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst-mid read strobe", 32'(mem_read), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst-mid ready", 32'(req_ready), 32'd1);
        chk("rst-mid strobes", {30'd0, mem_read, mem_write}, 32'd0);
        cnt_w = 0; cnt_r = 0;
        for (int c = 0; c < 5; c++) begin
            if (mem_write) cnt_w++;
            if (resp_valid) cnt_r++;
            @(posedge clk); #1;
        end
        chk("rst-mid no write", cnt_w, 0);
        chk("rst-mid no resp", cnt_r, 0);
        run_check("LW 4 after rst", 4'b0011, 8'h04, 32'h0, pre_word, 1'b0, 2, 1, 0, 32'h0);

        // Back-to-back with req_valid held high.
        b_op[0] = 4'b0011; b_ad[0] = 8'h10;
        b_op[1] = 4'b1000; b_ad[1] = 8'h21;
        b_op[2] = 4'b0101; b_ad[2] = 8'h12;
        b_op[3] = 4'b1111; b_ad[3] = 8'h00;
        for (int i = 0; i < 4; i++) ref_op(b_op[i], b_ad[i], 32'hC3, m_rd, m_err, m_lat, m_nr, m_nw, m_ww);
        idx = 0; resp_cnt = 0; busy_rdy = 0;
        req_valid = 1'b1; req_op = b_op[0]; req_addr = {24'd0, b_ad[0]}; req_wdata = 32'hC3;
        for (int c = 0; c < 40; c++) begin
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin req_op = b_op[idx]; req_addr = {24'd0, b_ad[idx]}; end
                else req_valid = 1'b0;
            end
            if (resp_valid) resp_cnt++;
            if ((resp_valid || mem_read || mem_write) && req_ready) busy_rdy++;
        end
        req_valid = 1'b0;
        chk("b2b accepts", idx, 4);
        chk("b2b responses", resp_cnt, 4);
        chk("b2b ready while busy", busy_rdy, 0);

        // Randomized traffic against the byte-array model.
        legal_ops = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011};
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
            else op = 4'($urandom);
            a = 8'($urandom_range(0, 255));
            wd = $urandom;
            ref_op(op, a, wd, m_rd, m_err, m_lat, m_nr, m_nw, m_ww);
            run_check($sformatf("rand%0d op%0h a%02h", n, op, a), op, a, wd, m_rd, m_err,
                      m_lat, m_nr, m_nw, m_ww);
        end

        for (int i = 0; i < 64; i++) chk($sformatf("final mem[%0d]", i), mem[i], rb_word(4*i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
